// File: rtl/debug_bus_master.sv
// debug_bus_master
//   Initiator for the VexRiscv debug bus. Turns high-level debug operations
//   (status read, halt, resume, step, instruction inject, data read, reset
//   pulse) into one or more debug-bus command transactions and returns a
//   single response per request.
//
// Ports
//   clk, reset             clock, asynchronous active-low reset
//   req_valid/ready        operation request handshake
//   req_op, req_data       operation code and INJECT instruction word
//   rsp_valid/ready        response handshake
//   rsp_data, rsp_err      response payload and failure flag
//   busy                   operation in progress
//   cmd_valid/ready        debug command handshake
//   cmd_payload_*          debug command write flag, address, write data
//   dbg_rsp_data           responder read data (cycle after a read fire)
//   resetOut               core reset request from the responder
module debug_bus_master #(
  parameter int unsigned POLL_MAX = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_payload_wr,
  output logic [7:0]  cmd_payload_address,
  output logic [31:0] cmd_payload_data,
  input  logic [31:0] dbg_rsp_data,
  input  logic        resetOut
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CMD      = 3'd1,
    S_CAPTURE  = 3'd2,
    S_POLL_CMD = 3'd3,
    S_POLL_CAP = 3'd4,
    S_RESP     = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    OP_STATUS      = 3'd0,
    OP_HALT        = 3'd1,
    OP_RESUME      = 3'd2,
    OP_STEP        = 3'd3,
    OP_INJECT      = 3'd4,
    OP_READ_DATA   = 3'd5,
    OP_RESET_PULSE = 3'd6,
    OP_RESERVED    = 3'd7
  } op_t;

  localparam logic [7:0]  ADDR_CTRL   = 8'h00;
  localparam logic [7:0]  ADDR_DATA   = 8'h04;
  localparam logic [31:0] D_HALT      = 32'h0002_0000;
  localparam logic [31:0] D_RESUME    = 32'h0200_0000;
  localparam logic [31:0] D_STEP      = 32'h0200_0010;
  localparam logic [31:0] D_RST_SET   = 32'h0001_0000;
  localparam logic [31:0] D_RST_CLR   = 32'h0100_0000;
  localparam logic [8:0]  POLL_LIMIT  = 9'(POLL_MAX);

  state_t      state;
  state_t      state_next;
  op_t         op;
  logic [31:0] data;
  logic        second;       // RESET_PULSE: first write already fired
  logic [7:0]  poll_cnt;

  logic        fire;
  logic        issue;
  logic        next_wr;
  logic [7:0]  next_addr;
  logic [31:0] next_data;
  logic [8:0]  poll_next;
  logic        poll_exhausted;

  assign fire           = cmd_valid && cmd_ready;
  assign poll_next      = {1'b0, poll_cnt} + 9'd1;
  assign poll_exhausted = (poll_next >= POLL_LIMIT);

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign rsp_valid = (state == S_RESP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A command-issuing state first spends one cycle with cmd_valid low, then
  // raises cmd_valid with its payload registered. This guarantees the idle
  // cycle between consecutive commands and keeps the payload frozen while
  // cmd_valid is high.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    next_wr    = 1'b0;
    next_addr  = '0;
    next_data  = '0;
    unique case (state)
      S_IDLE: begin
        if (req_valid) begin
          state_next = (req_op == OP_RESERVED) ? S_RESP : S_CMD;
        end
      end
      S_CMD: begin
        issue = !cmd_valid;
        unique case (op)
          OP_STATUS:      begin next_wr = 1'b0; next_addr = ADDR_CTRL; end
          OP_HALT:        begin next_wr = 1'b1; next_addr = ADDR_CTRL; next_data = D_HALT;   end
          OP_RESUME:      begin next_wr = 1'b1; next_addr = ADDR_CTRL; next_data = D_RESUME; end
          OP_STEP:        begin next_wr = 1'b1; next_addr = ADDR_CTRL; next_data = D_STEP;   end
          OP_INJECT:      begin next_wr = 1'b1; next_addr = ADDR_DATA; next_data = data;     end
          OP_READ_DATA:   begin next_wr = 1'b0; next_addr = ADDR_DATA; end
          OP_RESET_PULSE: begin
            next_wr   = 1'b1;
            next_addr = ADDR_CTRL;
            next_data = second ? D_RST_CLR : D_RST_SET;
          end
          OP_RESERVED:    begin next_wr = 1'b0; end
        endcase
        if (fire) begin
          if (op == OP_STATUS || op == OP_READ_DATA) begin
            state_next = S_CAPTURE;
          end else if (op == OP_INJECT) begin
            state_next = S_POLL_CMD;
          end else if (op == OP_RESET_PULSE && !second) begin
            state_next = S_CMD;
          end else begin
            state_next = S_RESP;
          end
        end
      end
      S_CAPTURE: begin
        state_next = S_RESP;
      end
      S_POLL_CMD: begin
        issue     = !cmd_valid;
        next_wr   = 1'b0;
        next_addr = ADDR_CTRL;
        if (fire) begin
          state_next = S_POLL_CAP;
        end
      end
      S_POLL_CAP: begin
        if (!dbg_rsp_data[2] || poll_exhausted) begin
          state_next = S_RESP;
        end else begin
          state_next = S_POLL_CMD;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op                  <= OP_STATUS;
      data                <= '0;
      second              <= 1'b0;
      poll_cnt            <= '0;
      cmd_valid           <= 1'b0;
      cmd_payload_wr      <= 1'b0;
      cmd_payload_address <= '0;
      cmd_payload_data    <= '0;
      rsp_data            <= '0;
      rsp_err             <= 1'b0;
    end else begin
      if (state == S_IDLE && req_valid) begin
        op       <= op_t'(req_op);
        data     <= req_data;
        second   <= 1'b0;
        poll_cnt <= '0;
        rsp_data <= '0;
        rsp_err  <= (req_op == OP_RESERVED);
      end

      if (fire) begin
        cmd_valid <= 1'b0;
      end else if (issue) begin
        cmd_valid           <= 1'b1;
        cmd_payload_wr      <= next_wr;
        cmd_payload_address <= next_addr;
        cmd_payload_data    <= next_data;
      end

      if (fire && state == S_CMD && op == OP_RESET_PULSE) begin
        second <= 1'b1;
      end

      // STATUS reports the responder's live reset request in bit 31.
      if (state == S_CAPTURE) begin
        rsp_data <= (op == OP_STATUS) ? {resetOut, dbg_rsp_data[30:0]} : dbg_rsp_data;
      end

      if (state == S_POLL_CAP) begin
        rsp_data <= dbg_rsp_data;
        poll_cnt <= poll_cnt + 8'd1;
        if (dbg_rsp_data[2] && poll_exhausted) begin
          rsp_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_debug_bus_master.sv
module tb_debug_bus_master;

  localparam int unsigned POLL = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [31:0] req_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic        cmd_payload_wr;
  logic [7:0]  cmd_payload_address;
  logic [31:0] cmd_payload_data;
  logic [31:0] dbg_rsp_data = '0;
  logic        resetOut = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  debug_bus_master #(.POLL_MAX(POLL)) dut (
    .clk                 (clk),
    .reset               (reset),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_op              (req_op),
    .req_data            (req_data),
    .rsp_valid           (rsp_valid),
    .rsp_ready           (rsp_ready),
    .rsp_data            (rsp_data),
    .rsp_err             (rsp_err),
    .busy                (busy),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_payload_wr      (cmd_payload_wr),
    .cmd_payload_address (cmd_payload_address),
    .cmd_payload_data    (cmd_payload_data),
    .dbg_rsp_data        (dbg_rsp_data),
    .resetOut            (resetOut)
  );

  // Commands are {wr, addr, data}.
  logic [40:0] obs[$];
  logic [40:0] exp_cmds[$];
  logic [31:0] rd_q[$];
  logic [31:0] rd_plan[$];
  int unsigned stall_n = 0;
  bit          bp_en = 1'b0;
  logic        prev_valid = 1'b0;
  logic        prev_fire = 1'b0;
  logic [40:0] prev_pl = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Debug-bus responder: picks cmd_ready for the coming edge, records fires,
  // serves read data for the following cycle, and watches the handshake rules.
  always @(negedge clk) begin : responder
    bit          rfire;
    logic [40:0] pl;
    pl = {cmd_payload_wr, cmd_payload_address, cmd_payload_data};
    if (!reset) begin
      prev_valid = 1'b0;
      prev_fire  = 1'b0;
      cmd_ready  = 1'b0;
    end else begin
      if (prev_valid && !prev_fire) begin
        check("cmd_hold", cmd_valid, 1);
        if (cmd_valid) check("cmd_payload_stable", pl, prev_pl);
      end
      if (prev_fire) check("cmd_gap", cmd_valid, 0);
      if (stall_n > 0 && cmd_valid) begin
        cmd_ready = 1'b0;
        stall_n--;
      end else if (bp_en) begin
        cmd_ready = 1'($urandom_range(0, 1));
      end else begin
        cmd_ready = 1'b1;
      end
      rfire = cmd_valid && cmd_ready;
      if (rfire) begin
        obs.push_back(pl);
        if (!cmd_payload_wr) dbg_rsp_data = (rd_q.size() > 0) ? rd_q.pop_front() : 32'hDEAD_BEEF;
      end
      prev_valid = cmd_valid;
      prev_fire  = rfire;
      prev_pl    = pl;
    end
  end

  // Reference model: expected command list, response and latency derived from
  // the operation rules and the planned responder read data.
  task automatic model(input logic [2:0] op, input logic [31:0] d, input logic ro,
                       output logic [31:0] rdat, output logic rerr, output int lat);
    int          nrd;
    logic [31:0] s;
    exp_cmds.delete();
    rdat = '0;
    rerr = 1'b0;
    case (op)
      3'd0: begin
        exp_cmds.push_back({1'b0, 8'h00, 32'h0});
        s = rd_plan[0];
        rdat = {ro, s[30:0]};
      end
      3'd1: exp_cmds.push_back({1'b1, 8'h00, 32'h0002_0000});
      3'd2: exp_cmds.push_back({1'b1, 8'h00, 32'h0200_0000});
      3'd3: exp_cmds.push_back({1'b1, 8'h00, 32'h0200_0010});
      3'd4: begin
        exp_cmds.push_back({1'b1, 8'h04, d});
        for (int i = 0; i < int'(POLL); i++) begin
          exp_cmds.push_back({1'b0, 8'h00, 32'h0});
          rdat = rd_plan[i];
          if (rdat[2] == 1'b0) break;
          if (i == int'(POLL) - 1) rerr = 1'b1;
        end
      end
      3'd5: begin
        exp_cmds.push_back({1'b0, 8'h04, 32'h0});
        rdat = rd_plan[0];
      end
      3'd6: begin
        exp_cmds.push_back({1'b1, 8'h00, 32'h0001_0000});
        exp_cmds.push_back({1'b1, 8'h00, 32'h0100_0000});
      end
      default: rerr = 1'b1;
    endcase
    nrd = 0;
    foreach (exp_cmds[i]) if (exp_cmds[i][40] == 1'b0) nrd++;
    lat = 1 + 2 * exp_cmds.size() + nrd;
  endtask

  // Issues one request at a negedge, waits for the response, holds rsp_ready
  // low for 'hold' cycles, consumes it and returns the observed response.
  task automatic run_op(input logic [2:0] op, input logic [31:0] d, input int hold,
                        output logic [31:0] rdat, output logic rerr, output int lat);
    int          t;
    logic [31:0] held;
    obs.delete();
    rd_q = rd_plan;
    req_op    = op;
    req_data  = d;
    req_valid = 1'b1;
    t = 0;
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("req_accept", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    req_op    = 3'($urandom);
    req_data  = $urandom;
    check("busy_after_accept", {req_ready, busy}, 2'b01);
    lat = 1;
    while (!rsp_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    check("rsp_valid", rsp_valid, 1);
    rdat = rsp_data;
    rerr = rsp_err;
    held = rsp_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("rsp_hold", {rsp_valid, req_ready, rsp_err, rsp_data}, {1'b1, 1'b0, rerr, held});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_done", {rsp_valid, req_ready, busy}, 3'b010);
  endtask

  task automatic cmp_cmds(input string tag);
    check({tag, "_count"}, obs.size(), exp_cmds.size());
    for (int i = 0; i < exp_cmds.size() && i < obs.size(); i++) check(tag, obs[i], exp_cmds[i]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, {req_ready, rsp_valid, rsp_err, busy, cmd_valid}, 5'b10000);
    check({tag, "_payload"}, {cmd_payload_wr, cmd_payload_address, cmd_payload_data}, 41'h0);
    check({tag, "_rsp_data"}, rsp_data, 32'h0);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] data;
    logic [31:0] rd;
    logic        ro;
    int          ncmd;
    logic [40:0] cmd;
    logic [31:0] exp_rsp;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vt[8];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] ar, er, v;
    logic        ae, ee;
    int          al, el, t, hold;
    logic [2:0]  op;
    logic [31:0] d;

    vt[0] = '{3'd1, 32'h0,         32'h0,         1'b0, 1, {1'b1, 8'h00, 32'h0002_0000}, 32'h0,         1'b0, 3};
    vt[1] = '{3'd2, 32'h0,         32'h0,         1'b0, 1, {1'b1, 8'h00, 32'h0200_0000}, 32'h0,         1'b0, 3};
    vt[2] = '{3'd3, 32'hFFFF_FFFF, 32'h0,         1'b1, 1, {1'b1, 8'h00, 32'h0200_0010}, 32'h0,         1'b0, 3};
    vt[3] = '{3'd0, 32'h0,         32'h0000_0002, 1'b1, 1, {1'b0, 8'h00, 32'h0},         32'h8000_0002, 1'b0, 4};
    vt[4] = '{3'd0, 32'h0,         32'hFFFF_FFFF, 1'b0, 1, {1'b0, 8'h00, 32'h0},         32'h7FFF_FFFF, 1'b0, 4};
    vt[5] = '{3'd5, 32'h0,         32'h1234_5678, 1'b1, 1, {1'b0, 8'h04, 32'h0},         32'h1234_5678, 1'b0, 4};
    vt[6] = '{3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 41'h0,                        32'h0,         1'b1, 1};
    vt[7] = '{3'd0, 32'h0,         32'h8000_0000, 1'b0, 1, {1'b0, 8'h00, 32'h0},         32'h0,         1'b0, 4};

    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("reset_initial");
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset_clocked");
    reset = 1'b1;
    @(negedge clk);

    // Vector table, cmd_ready tied high.
    foreach (vt[k]) begin
      rd_plan.delete();
      for (int i = 0; i < int'(POLL); i++) rd_plan.push_back(vt[k].rd);
      resetOut = vt[k].ro;
      exp_cmds.delete();
      if (vt[k].ncmd == 1) exp_cmds.push_back(vt[k].cmd);
      run_op(vt[k].op, vt[k].data, 0, ar, ae, al);
      check("vec_rsp_data", ar, vt[k].exp_rsp);
      check("vec_rsp_err", ae, vt[k].exp_err);
      check("vec_latency", al, vt[k].exp_lat);
      cmp_cmds("vec_cmd");
    end

    // RESUME with cmd_ready low for 5 cycles while cmd_valid is up.
    resetOut = 1'b0;
    rd_plan.delete();
    for (int i = 0; i < int'(POLL); i++) rd_plan.push_back(32'h0);
    stall_n = 5;
    run_op(3'd2, 32'h0, 0, ar, ae, al);
    check("stall_consumed", stall_n, 0);
    check("stall_rsp", {ae, ar}, 33'h0);
    exp_cmds.delete();
    exp_cmds.push_back({1'b1, 8'h00, 32'h0200_0000});
    cmp_cmds("stall_cmd");
    stall_n = 0;

    // INJECT: busy for two polls, then clear on the third.
    rd_plan.delete();
    rd_plan.push_back(32'h0000_0104);
    rd_plan.push_back(32'h0000_0004);
    rd_plan.push_back(32'h0000_0001);
    rd_plan.push_back(32'hFFFF_FFFF);
    run_op(3'd4, 32'h0000_0013, 0, ar, ae, al);
    check("inject_rsp_data", ar, 32'h0000_0001);
    check("inject_rsp_err", ae, 0);
    check("inject_latency", al, 12);
    exp_cmds.delete();
    exp_cmds.push_back({1'b1, 8'h04, 32'h0000_0013});
    for (int i = 0; i < 3; i++) exp_cmds.push_back({1'b0, 8'h00, 32'h0});
    cmp_cmds("inject_cmd");

    // INJECT with the pipeline-busy bit stuck high: POLL polls then error.
    rd_plan.delete();
    rd_plan.push_back(32'h0000_0004);
    rd_plan.push_back(32'h0000_0005);
    rd_plan.push_back(32'h0000_0006);
    rd_plan.push_back(32'h0000_0007);
    run_op(3'd4, 32'hCAFE_0013, 1, ar, ae, al);
    check("stuck_rsp_data", ar, 32'h0000_0007);
    check("stuck_rsp_err", ae, 1);
    check("stuck_latency", al, 15);
    exp_cmds.delete();
    exp_cmds.push_back({1'b1, 8'h04, 32'hCAFE_0013});
    for (int i = 0; i < int'(POLL); i++) exp_cmds.push_back({1'b0, 8'h00, 32'h0});
    cmp_cmds("stuck_cmd");

    // RESET_PULSE with the response held for 3 cycles.
    run_op(3'd6, 32'h0, 3, ar, ae, al);
    check("pulse_rsp", {ae, ar}, 33'h0);
    check("pulse_latency", al, 5);
    exp_cmds.delete();
    exp_cmds.push_back({1'b1, 8'h00, 32'h0001_0000});
    exp_cmds.push_back({1'b1, 8'h00, 32'h0100_0000});
    cmp_cmds("pulse_cmd");

    // Reset asserted while INJECT is polling: abandon without a response.
    rd_plan.delete();
    for (int i = 0; i < int'(POLL); i++) rd_plan.push_back(32'h0000_0004);
    obs.delete();
    rd_q = rd_plan;
    req_op    = 3'd4;
    req_data  = 32'h0000_0013;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    t = 0;
    while (obs.size() < 3 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("reset_poll_reached", obs.size() >= 3, 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_outputs("reset_async");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_reset_outputs("reset_held");
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_no_rsp", {rsp_valid, busy, cmd_valid, req_ready}, 4'b0001);
    end
    obs.delete();
    rd_q.delete();

    // Randomised operations against the reference model.
    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(0, 7));
      d  = $urandom;
      rd_plan.delete();
      for (int i = 0; i < int'(POLL); i++) begin
        v = $urandom;
        v[2] = ($urandom_range(0, 9) < 6);
        rd_plan.push_back(v);
      end
      resetOut = 1'($urandom_range(0, 1));
      bp_en    = 1'($urandom_range(0, 1));
      hold     = int'($urandom_range(0, 2));
      model(op, d, resetOut, er, ee, el);
      run_op(op, d, hold, ar, ae, al);
      check("rand_rsp_data", ar, er);
      check("rand_rsp_err", ae, ee);
      if (!bp_en) check("rand_latency", al, el);
      cmp_cmds("rand_cmd");
    end
    bp_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debug_bus_master.md
Name: debug_bus_master

Overview:
- Initiator for the VexRiscv debug bus, acting as the drv-side counterpart of the CPU debug responder.
- Accepts high-level debug operations (status read, halt, resume, step, instruction inject, data read, reset pulse) on a valid/ready request port.
- Sequences each operation into one or more debug-bus command transactions and returns one response per request.
- Used by the verification environment and the JTAG bridge to control the core.

Parameters:
- POLL_MAX, 16, maximum status polls after INJECT before an error response is returned (1..255).

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- req_valid  input  1  operation request valid
- req_ready  output  1  master can accept a request
- req_op  input  3  0 STATUS, 1 HALT, 2 RESUME, 3 STEP, 4 INJECT, 5 READ_DATA, 6 RESET_PULSE, 7 reserved
- req_data  input  32  instruction word for INJECT; ignored otherwise
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response consumed
- rsp_data  output  32  response payload
- rsp_err  output  1  operation failed (reserved op or poll timeout)
- busy  output  1  operation in progress (any state other than IDLE)
- cmd_valid  output  1  debug command valid
- cmd_ready  input  1  debug command accepted
- cmd_payload_wr  output  1  1 = write, 0 = read
- cmd_payload_address  output  8  0x00 control/status, 0x04 inject/data
- cmd_payload_data  output  32  write data
- dbg_rsp_data  input  32  responder read data, valid the cycle after read fire
- resetOut  input  1  core reset request from the responder

Behaviour:
- Reset (reset=0, asynchronous):
  - Enters IDLE.
  - All outputs are 0 except req_ready, which is 1.
  - cmd_payload_* are 0.
  - Any operation in flight is abandoned and no response is emitted.
- States: IDLE, CMD, CAPTURE, POLL_CMD, POLL_CAP, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch op and data, drop req_ready, and go to CMD next cycle.
  - A reserved op (7) goes directly to RESP with rsp_err=1 and rsp_data=0.
- Command fire: cmd_valid && cmd_ready.
  - cmd_valid and payload stay stable until fire; payload never changes while cmd_valid=1.
  - After fire, cmd_valid drops the next cycle. No back-to-back fires; at least one idle cycle between commands.
- Op encodings:
  - STATUS: read 0x00.
  - HALT: write 0x00, data 0x0002_0000.
  - RESUME: write 0x00, data 0x0200_0000.
  - STEP: write 0x00, data 0x0200_0010.
  - INJECT: write 0x04, data req_data, then poll.
  - READ_DATA: read 0x04.
  - RESET_PULSE: write 0x00 data 0x0001_0000, then write 0x00 data 0x0100_0000 as a second CMD.
- Read ops (STATUS, READ_DATA):
  - CMD fire moves to CAPTURE.
  - In CAPTURE, rsp_data <= dbg_rsp_data, except that for STATUS bit31 is replaced by resetOut sampled in the same cycle.
  - Then RESP.
- Write ops: the final fire moves to RESP with rsp_data=0.
- INJECT polling:
  - After the write fire, go to POLL_CMD and issue a read of 0x00.
  - In POLL_CAP, test dbg_rsp_data bit2 (pipeline busy). If bit2=0, go to RESP with rsp_err=0 and rsp_data=captured status.
  - Otherwise increment the poll counter and reissue.
  - If the count reaches POLL_MAX with bit2 still 1, go to RESP with rsp_err=1 and rsp_data=last status.
- RESP:
  - rsp_valid=1 with rsp_data and rsp_err held until rsp_ready.
  - Return to IDLE the cycle after rsp_valid && rsp_ready.
  - req_ready rises in that IDLE cycle; no request is accepted while a response is pending.
- Latency: minimum request-to-rsp_valid is 3 cycles for write ops and 4 cycles for reads with cmd_ready tied high.
- rsp_err resets to 0 at each new request.
- busy = (state != IDLE).

Test Plan:
- cmd_ready=1, HALT request → single write, addr 0x00, data 0x0002_0000. rsp_valid 3 cycles after acceptance, rsp_data=0, rsp_err=0.
- STATUS with dbg_rsp_data=0x0000_0002 and resetOut=1 → read of 0x00, rsp_data=0x8000_0002.
- cmd_ready held low for 5 cycles during RESUME → cmd_valid and payload stable for all 5 cycles. Exactly one fire; response follows.
- INJECT 0x0000_0013, busy bit2=1 for 2 polls then 0 → write 0x04 then 3 reads of 0x00. rsp_err=0, rsp_data shows bit2=0.
- INJECT with bit2 stuck at 1, POLL_MAX=4 → exactly 4 polls, then rsp_err=1. Also: req_op=7 → no cmd_valid, rsp_err=1, rsp_data=0.
- RESET_PULSE with rsp_ready low for 3 cycles, then reset asserted during a later INJECT poll → two writes (0x0001_0000, 0x0100_0000) and the response held for 3 cycles. After reset, all outputs are 0, req_ready=1, and no response is emitted.
